vx_ti_node_fetch: RTL

//  Upstream stage of the traversal memory unit. Takes BVH node fetch requests (base line addr + ray tag).

---
 rtl/vx_ti_node_fetch_pkg.sv | 31 +++
 rtl/vx_ti_node_fetch_buf.sv | 96 +++++++++
 rtl/vx_ti_node_fetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vx_ti_node_fetch_pkg.sv
// -----------------------------------------------------------------------------
// vx_ti_node_fetch_pkg
// Shared types and default sizing for the BVH node fetch stage.
//   - default geometry (node words, line width, address/tag widths, slots)
//   - issue FSM state encoding
//   - memory-side tag layout {slot, word_idx} for the default geometry
// -----------------------------------------------------------------------------
package vx_ti_node_fetch_pkg;

    localparam int unsigned NODE_WORDS_DEF = 4;
    localparam int unsigned WORD_WIDTH_DEF = 512;
    localparam int unsigned ADDR_WIDTH_DEF = 26;
    localparam int unsigned TAG_WIDTH_DEF  = 8;
    localparam int unsigned NUM_SLOTS_DEF  = 4;

    localparam int unsigned SLOT_W_DEF = $clog2(NUM_SLOTS_DEF);
    localparam int unsigned WIDX_W_DEF = $clog2(NODE_WORDS_DEF);

    // Issue FSM: IDLE accepts a node request, ISSUE walks its cache lines.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_e;

    // Tag carried with each cache read and echoed on the response.
    typedef struct packed {
        logic [SLOT_W_DEF-1:0] slot;
        logic [WIDX_W_DEF-1:0] word_idx;
    } mem_tag_t;

endpackage

// File: rtl/vx_ti_node_fetch_buf.sv
// -----------------------------------------------------------------------------
// vx_ti_node_fetch_buf
// Reassembly storage: one row of NODE_WORDS cache lines per slot, plus a
// presence bit per line. Reports per-slot completion as it will look after
// the current edge so the parent can register node_valid with one cycle of
// latency from the completing response.
// Ports:
//   clk, reset         clock, synchronous active-high reset (clears presence)
//   wr_valid/slot/word/data  incoming cache response
//   clr_valid/clr_slot       drop presence of a slot being delivered
//   alloc                    allocated-slot mask (response sanity checks)
//   rd_slot / rd_row_c       row read with same-cycle response bypass
//   complete_next_c          per-slot "all words present" after this edge
// -----------------------------------------------------------------------------
module vx_ti_node_fetch_buf #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned NODE_WORDS = 4,
    parameter int unsigned WORD_WIDTH = 512,
    parameter int unsigned SLOT_W     = $clog2(NUM_SLOTS),
    parameter int unsigned WIDX_W     = $clog2(NODE_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_valid,
    input  logic [SLOT_W-1:0]                wr_slot,
    input  logic [WIDX_W-1:0]                wr_word,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    input  logic                             clr_valid,
    input  logic [SLOT_W-1:0]                clr_slot,
    input  logic [NUM_SLOTS-1:0]             alloc,
    input  logic [SLOT_W-1:0]                rd_slot,
    output logic [NODE_WORDS*WORD_WIDTH-1:0] rd_row_c,
    output logic [NUM_SLOTS-1:0]             complete_next_c
);

    localparam int unsigned ROW_W = NODE_WORDS * WORD_WIDTH;

    logic [ROW_W-1:0]      data_mem     [NUM_SLOTS];
    logic [NODE_WORDS-1:0] present      [NUM_SLOTS];
    logic [NODE_WORDS-1:0] present_next [NUM_SLOTS];

    // Presence update: a delivered slot is cleared, a response sets its word.
    always_comb begin
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            present_next[s]    = present[s];
            if (clr_valid && (clr_slot == SLOT_W'(s))) begin
                present_next[s] = '0;
            end
            if (wr_valid && (wr_slot == SLOT_W'(s))) begin
                present_next[s][wr_word] = 1'b1;
            end
            complete_next_c[s] = &present_next[s];
        end
    end

    // Row read; a response landing in the read row this cycle is forwarded.
    always_comb begin
        rd_row_c = data_mem[rd_slot];
        for (int w = 0; w < int'(NODE_WORDS); w++) begin
            if (wr_valid && (wr_slot == rd_slot) && (wr_word == WIDX_W'(w))) begin
                rd_row_c[w*WORD_WIDTH +: WORD_WIDTH] = wr_data;
            end
        end
    end

    // Presence bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                present[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                present[s] <= present_next[s];
            end
        end
    end

    // Line storage; contents are only meaningful where presence is set.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            for (int w = 0; w < int'(NODE_WORDS); w++) begin
                if (wr_word == WIDX_W'(w)) begin
                    data_mem[wr_slot][w*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                end
            end
        end
    end

    // Responses must target a live slot and must not repeat a word.
    rsp_slot_allocated: assert property (@(posedge clk) disable iff (reset)
        wr_valid |-> alloc[wr_slot]);
    rsp_word_not_present: assert property (@(posedge clk) disable iff (reset)
        wr_valid |-> !present[wr_slot][wr_word]);

endmodule

// File: rtl/vx_ti_node_fetch.sv
// -----------------------------------------------------------------------------
// vx_ti_node_fetch
// Front stage of the traversal memory unit. Accepts BVH node requests, splits
// each node into NODE_WORDS cache-line reads, reassembles out-of-order
// responses in per-slot buffers and delivers whole nodes in request order.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/addr/tag, req_ready     node request (base line address, ray tag)
//   mem_req_valid/addr/tag/ready      cache line read, tag = {slot, word_idx}
//   mem_rsp_valid/data/tag, ready     cache response (always accepted)
//   node_valid/data/tag, node_ready   completed node, word i at [i*WORD_WIDTH]
// -----------------------------------------------------------------------------
module vx_ti_node_fetch
    import vx_ti_node_fetch_pkg::*;
#(
    parameter int unsigned NODE_WORDS    = NODE_WORDS_DEF,
    parameter int unsigned WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF,
    parameter int unsigned NUM_SLOTS     = NUM_SLOTS_DEF,
    parameter int unsigned MEM_TAG_WIDTH = $clog2(NUM_SLOTS) + $clog2(NODE_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             req_valid,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [TAG_WIDTH-1:0]             req_tag,
    output logic                             req_ready,

    output logic                             mem_req_valid,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [MEM_TAG_WIDTH-1:0]         mem_req_tag,
    input  logic                             mem_req_ready,

    input  logic                             mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]            mem_rsp_data,
    input  logic [MEM_TAG_WIDTH-1:0]         mem_rsp_tag,
    output logic                             mem_rsp_ready,

    output logic                             node_valid,
    output logic [NODE_WORDS*WORD_WIDTH-1:0] node_data,
    output logic [TAG_WIDTH-1:0]             node_tag,
    input  logic                             node_ready
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned WIDX_W = $clog2(NODE_WORDS);
    localparam int unsigned OCNT_W = SLOT_W + 1;
    localparam int unsigned ROW_W  = NODE_WORDS * WORD_WIDTH;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NODE_WORDS - 1);

    // Issue FSM state and current node being issued.
    fetch_state_e         state;
    fetch_state_e         state_next;
    logic [SLOT_W-1:0]    cur_slot;
    logic [WIDX_W-1:0]    cnt;

    // Slot allocation and per-slot ray tags.
    logic [NUM_SLOTS-1:0] alloc;
    logic [NUM_SLOTS-1:0] alloc_next;
    logic [TAG_WIDTH-1:0] tag_mem [NUM_SLOTS];
    logic [SLOT_W-1:0]    free_slot;

    // Order FIFO of slot ids, oldest at ord_rd.
    logic [SLOT_W-1:0]    ord_mem [NUM_SLOTS];
    logic [SLOT_W-1:0]    ord_rd;
    logic [SLOT_W-1:0]    ord_wr;
    logic [SLOT_W-1:0]    ord_rd_next;
    logic [OCNT_W-1:0]    ord_cnt;
    logic [OCNT_W-1:0]    ord_cnt_next;
    logic [OCNT_W-1:0]    ord_keep;

    logic                 req_fire;
    logic                 mem_fire;
    logic                 node_fire;
    logic                 issue_done;
    logic [SLOT_W-1:0]    head_slot;
    logic [SLOT_W-1:0]    head_next;
    logic                 node_valid_next;
    logic [ROW_W-1:0]     head_row;
    logic [NUM_SLOTS-1:0] complete_next;

    // Responses are always accepted: storage was reserved at allocation.
    assign mem_rsp_ready = 1'b1;

    assign req_fire   = req_valid & req_ready;
    assign mem_fire   = mem_req_valid & mem_req_ready;
    assign node_fire  = node_valid & node_ready;
    assign issue_done = mem_fire && (cnt == LAST_WORD);
    assign head_slot  = ord_mem[ord_rd];

    // Lowest-index free slot.
    always_comb begin
        free_slot = '0;
        for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
            if (!alloc[s]) begin
                free_slot = SLOT_W'(s);
            end
        end
    end

    // Next-cycle bookkeeping shared by the registered outputs.
    always_comb begin
        alloc_next = alloc;
        if (req_fire) begin
            alloc_next[free_slot] = 1'b1;
        end
        if (node_fire) begin
            alloc_next[head_slot] = 1'b0;
        end

        state_next = state;
        case (state)
            ST_IDLE:  if (req_fire)   state_next = ST_ISSUE;
            ST_ISSUE: if (issue_done) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase

        ord_keep     = ord_cnt - OCNT_W'(node_fire);
        ord_cnt_next = ord_keep + OCNT_W'(req_fire);
        ord_rd_next  = ord_rd + SLOT_W'(node_fire);

        // If only the entry being pushed now remains, it becomes the head.
        head_next       = (ord_keep != '0) ? ord_mem[ord_rd_next] : free_slot;
        node_valid_next = (ord_cnt_next != '0) && complete_next[head_next];
    end

    vx_ti_node_fetch_buf #(
        .NUM_SLOTS  (NUM_SLOTS),
        .NODE_WORDS (NODE_WORDS),
        .WORD_WIDTH (WORD_WIDTH),
        .SLOT_W     (SLOT_W),
        .WIDX_W     (WIDX_W)
    ) u_buf (
        .clk             (clk),
        .reset           (reset),
        .wr_valid        (mem_rsp_valid),
        .wr_slot         (mem_rsp_tag[MEM_TAG_WIDTH-1 -: SLOT_W]),
        .wr_word         (mem_rsp_tag[WIDX_W-1:0]),
        .wr_data         (mem_rsp_data),
        .clr_valid       (node_fire),
        .clr_slot        (head_slot),
        .alloc           (alloc),
        .rd_slot         (head_next),
        .rd_row_c        (head_row),
        .complete_next_c (complete_next)
    );

    // Issue FSM, allocator, order FIFO and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cur_slot      <= '0;
            cnt           <= '0;
            alloc         <= '0;
            ord_rd        <= '0;
            ord_wr        <= '0;
            ord_cnt       <= '0;
            req_ready     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_tag   <= '0;
            node_valid    <= 1'b0;
            node_data     <= '0;
            node_tag      <= '0;
        end else begin
            state     <= state_next;
            alloc     <= alloc_next;
            ord_rd    <= ord_rd_next;
            ord_cnt   <= ord_cnt_next;
            req_ready <= (state_next == ST_IDLE) && (alloc_next != '1);

            if (req_fire) begin
                ord_mem[ord_wr]    <= free_slot;
                ord_wr             <= ord_wr + SLOT_W'(1);
                tag_mem[free_slot] <= req_tag;
            end

            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        cur_slot      <= free_slot;
                        cnt           <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= req_addr;
                        mem_req_tag   <= {free_slot, WIDX_W'(0)};
                    end
                end
                ST_ISSUE: begin
                    // Address and tag only move on an accepted read.
                    if (mem_fire) begin
                        if (cnt == LAST_WORD) begin
                            mem_req_valid <= 1'b0;
                        end else begin
                            cnt          <= cnt + WIDX_W'(1);
                            mem_req_addr <= mem_req_addr + ADDR_WIDTH'(1);
                            mem_req_tag  <= {cur_slot, cnt + WIDX_W'(1)};
                        end
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                end
            endcase

            // Payload reloads only when a node will be presented; it is
            // unchanged while a stalled head is held.
            node_valid <= node_valid_next;
            if (node_valid_next) begin
                node_data <= head_row;
                node_tag  <= tag_mem[head_next];
            end
        end
    end

endmodule
